// File: rtl/bramfifo_wrarb.sv
// bramfifo_wrarb
//   Round-robin write arbiter that lets REQ_ producers share the single write
//   port of a bramfifo. A producer that wins arbitration keeps the port for up
//   to BURST_ beats, or until it flags the last beat of its packet. Accepted
//   beats are registered and then presented on the FIFO we/din pins.
//
// Ports
//   clk        rising-edge clock
//   rst_       asynchronous reset, active low
//   req_valid  per-requester beat available
//   req_last   per-requester beat ends its packet
//   req_data   per-requester beat, requester i in bits [i*DATA_ +: DATA_]
//   req_ready  per-requester beat accepted this cycle (at most one bit high)
//   grant      one-hot current winner/owner, zero when nobody is granted
//   fifo_fill  FIFO fill level
//   fifo_we    FIFO write enable (registered)
//   fifo_din   FIFO write data (registered, holds when no write)
module bramfifo_wrarb #(
  parameter int DATA_  = 8,
  parameter int ADDR_  = 8,
  parameter int REQ_   = 4,
  parameter int BURST_ = 4
) (
  input  logic                    clk,
  input  logic                    rst_,
  input  logic [REQ_-1:0]         req_valid,
  input  logic [REQ_-1:0]         req_last,
  input  logic [REQ_*DATA_-1:0]   req_data,
  output logic [REQ_-1:0]         req_ready,
  output logic [REQ_-1:0]         grant,
  input  logic [ADDR_:0]          fifo_fill,
  output logic                    fifo_we,
  output logic [DATA_-1:0]        fifo_din
);

  localparam int PW = (REQ_ > 1) ? $clog2(REQ_) : 1;
  localparam int CW = $clog2(BURST_ + 1);
  localparam logic [ADDR_+1:0] DEPTH = (ADDR_ + 2)'(1) << ADDR_;

  typedef enum logic {IDLE, LOCK} state_t;

  state_t          state, state_n;
  logic [PW-1:0]   ptr, ptr_n;
  logic [PW-1:0]   owner, owner_n;
  logic [CW-1:0]   cnt, cnt_n;

  logic [ADDR_+1:0] fill_sum;
  logic             space;
  logic [PW-1:0]    win;
  logic             found;
  logic [PW-1:0]    sel;
  logic             have;
  logic             sel_valid;
  logic             sel_last;
  logic [DATA_-1:0] sel_data;
  logic             accept;

  function automatic logic [PW-1:0] inc_mod(input logic [PW-1:0] v);
    if (int'(v) == REQ_ - 1) return '0;
    return v + 1'b1;
  endfunction

  // The write registered last cycle may not be reflected in fifo_fill yet, so
  // count it as occupied. A concurrent read is deliberately not credited.
  assign fill_sum = {1'b0, fifo_fill} + {{(ADDR_ + 1){1'b0}}, fifo_we};
  assign space    = fill_sum < DEPTH;

  // Rotating priority scan starting at ptr.
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < REQ_; k++) begin
      int idx;
      idx = int'(ptr) + k;
      if (idx >= REQ_) idx = idx - REQ_;
      if (!found && req_valid[PW'(idx)]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
  end

  // In LOCK the owner stays granted even when its valid drops, so the release
  // decision below can see it.
  always_comb begin
    sel       = (state == LOCK) ? owner : win;
    have      = (state == LOCK) ? 1'b1 : found;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int k = 0; k < REQ_; k++) begin
      if (PW'(k) == sel) begin
        sel_valid = req_valid[k];
        sel_last  = req_last[k];
        sel_data  = req_data[k*DATA_ +: DATA_];
      end
    end
  end

  // Outputs are gated by rst_ so they drop immediately on reset assertion.
  assign accept = rst_ && have && sel_valid && space;

  always_comb begin
    grant     = '0;
    req_ready = '0;
    for (int k = 0; k < REQ_; k++) begin
      grant[k]     = rst_ && have && (PW'(k) == sel);
      req_ready[k] = accept && (PW'(k) == sel);
    end
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    owner_n = owner;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          if (sel_last || BURST_ == 1) begin
            ptr_n = inc_mod(win);
          end else begin
            state_n = LOCK;
            owner_n = win;
            cnt_n   = CW'(1);
          end
        end
      end
      LOCK: begin
        if (!sel_valid) begin
          state_n = IDLE;
          ptr_n   = inc_mod(owner);
          cnt_n   = '0;
        end else if (accept) begin
          if (sel_last || (int'(cnt) + 1 == BURST_)) begin
            state_n = IDLE;
            ptr_n   = inc_mod(owner);
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state <= IDLE;
      ptr   <= '0;
      owner <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      owner <= owner_n;
      cnt   <= cnt_n;
    end
  end

  // Write stage: handshake at edge k lands on the FIFO pins after edge k.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      fifo_we  <= 1'b0;
      fifo_din <= '0;
    end else begin
      fifo_we <= accept;
      if (accept) fifo_din <= sel_data;
    end
  end

endmodule

// File: tb/tb_bramfifo_wrarb.sv
module tb_bramfifo_wrarb;

  logic        clk = 1'b0;
  logic        rst_;
  logic [3:0]  valid, last, ready, grant;
  logic [31:0] data;
  logic [8:0]  fill;
  logic        we;
  logic [7:0]  din;

  logic        valid1, last1, ready1, grant1, we1;
  logic [7:0]  data1, din1;
  logic [8:0]  fill1;

  int nchk  = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  bramfifo_wrarb #(.DATA_(8), .ADDR_(8), .REQ_(4), .BURST_(4)) dut (
    .clk(clk), .rst_(rst_), .req_valid(valid), .req_last(last), .req_data(data),
    .req_ready(ready), .grant(grant), .fifo_fill(fill), .fifo_we(we), .fifo_din(din)
  );

  bramfifo_wrarb #(.DATA_(8), .ADDR_(8), .REQ_(1), .BURST_(1)) dut1 (
    .clk(clk), .rst_(rst_), .req_valid(valid1), .req_last(last1), .req_data(data1),
    .req_ready(ready1), .grant(grant1), .fifo_fill(fill1), .fifo_we(we1), .fifo_din(din1)
  );

  typedef struct {
    logic [3:0]  valid;
    logic [3:0]  last;
    logic [31:0] data;
    logic [8:0]  fill;
    logic [3:0]  ready;
    logic [3:0]  grant;
    logic        we;
    logic [7:0]  din;
  } vec_t;

  vec_t vecs[24];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    //            valid    last     data          fill    ready    grant    we    din
    vecs[0]  = '{4'b1111, 4'b1111, 32'hD3C2B1A0, 9'd0,   4'b0001, 4'b0001, 1'b0, 8'h00};
    vecs[1]  = '{4'b1111, 4'b1111, 32'hD3C2B1A0, 9'd0,   4'b0010, 4'b0010, 1'b1, 8'hA0};
    vecs[2]  = '{4'b1111, 4'b1111, 32'hD3C2B1A0, 9'd0,   4'b0100, 4'b0100, 1'b1, 8'hB1};
    vecs[3]  = '{4'b1111, 4'b1111, 32'hD3C2B1A0, 9'd0,   4'b1000, 4'b1000, 1'b1, 8'hC2};
    vecs[4]  = '{4'b1111, 4'b1111, 32'hD3C2B1A0, 9'd0,   4'b0001, 4'b0001, 1'b1, 8'hD3};
    // req1 six-beat packet against single-beat req2
    vecs[5]  = '{4'b0110, 4'b0100, 32'h00E01100, 9'd0,   4'b0010, 4'b0010, 1'b1, 8'hA0};
    vecs[6]  = '{4'b0110, 4'b0100, 32'h00E01200, 9'd0,   4'b0010, 4'b0010, 1'b1, 8'h11};
    vecs[7]  = '{4'b0110, 4'b0100, 32'h00E01300, 9'd0,   4'b0010, 4'b0010, 1'b1, 8'h12};
    vecs[8]  = '{4'b0110, 4'b0100, 32'h00E01400, 9'd0,   4'b0010, 4'b0010, 1'b1, 8'h13};
    vecs[9]  = '{4'b0110, 4'b0100, 32'h00E01500, 9'd0,   4'b0100, 4'b0100, 1'b1, 8'h14};
    vecs[10] = '{4'b0010, 4'b0000, 32'h00001500, 9'd0,   4'b0010, 4'b0010, 1'b1, 8'hE0};
    vecs[11] = '{4'b0010, 4'b0010, 32'h00001600, 9'd0,   4'b0010, 4'b0010, 1'b1, 8'h15};
    // req3 drops valid after two beats
    vecs[12] = '{4'b1000, 4'b0000, 32'h31000000, 9'd0,   4'b1000, 4'b1000, 1'b1, 8'h16};
    vecs[13] = '{4'b1000, 4'b0000, 32'h32000000, 9'd0,   4'b1000, 4'b1000, 1'b1, 8'h31};
    vecs[14] = '{4'b0000, 4'b0000, 32'h00000000, 9'd0,   4'b0000, 4'b1000, 1'b1, 8'h32};
    vecs[15] = '{4'b0000, 4'b0000, 32'h00000000, 9'd0,   4'b0000, 4'b0000, 1'b0, 8'h32};
    // ptr must be 0 now; then fullness corner cases
    vecs[16] = '{4'b1001, 4'b1001, 32'h43000040, 9'd0,   4'b0001, 4'b0001, 1'b0, 8'h32};
    vecs[17] = '{4'b1001, 4'b1001, 32'h43000040, 9'd255, 4'b0000, 4'b1000, 1'b1, 8'h40};
    vecs[18] = '{4'b1001, 4'b1001, 32'h43000040, 9'd254, 4'b1000, 4'b1000, 1'b0, 8'h40};
    vecs[19] = '{4'b1001, 4'b1001, 32'h43000040, 9'd255, 4'b0000, 4'b0001, 1'b1, 8'h43};
    vecs[20] = '{4'b0000, 4'b0000, 32'h00000000, 9'd255, 4'b0000, 4'b0000, 1'b0, 8'h43};
    // LOCK stalls while full
    vecs[21] = '{4'b0100, 4'b0000, 32'h00500000, 9'd0,   4'b0100, 4'b0100, 1'b0, 8'h43};
    vecs[22] = '{4'b0110, 4'b0000, 32'h00506100, 9'd256, 4'b0000, 4'b0100, 1'b1, 8'h50};
    vecs[23] = '{4'b0110, 4'b0000, 32'h00506100, 9'd0,   4'b0100, 4'b0100, 1'b0, 8'h50};

    rst_ = 1'b0;
    valid = 4'b1111; last = 4'b1111; data = 32'hD3C2B1A0; fill = '0;
    valid1 = 1'b1; last1 = 1'b0; data1 = 8'h00; fill1 = '0;
    @(negedge clk); #1;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_ready", 32'(ready), 32'h0);
    chk("rst_we", 32'(we), 32'h0);
    chk("rst_din", 32'(din), 32'h0);
    chk("rst_ready1", 32'(ready1), 32'h0);
    valid = '0; valid1 = 1'b0;
    @(negedge clk);
    rst_ = 1'b1;

    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      valid = vecs[i].valid; last = vecs[i].last; data = vecs[i].data; fill = vecs[i].fill;
      #1;
      chk($sformatf("v%0d_ready", i), 32'(ready), 32'(vecs[i].ready));
      chk($sformatf("v%0d_grant", i), 32'(grant), 32'(vecs[i].grant));
      chk($sformatf("v%0d_we", i),    32'(we),    32'(vecs[i].we));
      chk($sformatf("v%0d_din", i),   32'(din),   32'(vecs[i].din));
    end

    // Reset asserted mid-burst (req2 owns the port with cnt=2).
    @(negedge clk);
    #1;
    chk("pre_rst_grant", 32'(grant), 32'h4);
    chk("pre_rst_we", 32'(we), 32'h1);
    rst_ = 1'b0;
    #1;
    chk("mid_rst_grant", 32'(grant), 32'h0);
    chk("mid_rst_ready", 32'(ready), 32'h0);
    chk("mid_rst_we", 32'(we), 32'h0);
    chk("mid_rst_din", 32'(din), 32'h0);
    @(negedge clk);
    rst_ = 1'b1;
    valid = 4'b1111; last = 4'b1111; data = 32'hD3C2B1A0; fill = '0;
    #1;
    chk("post_rst_grant", 32'(grant), 32'h1);
    chk("post_rst_ready", 32'(ready), 32'h1);
    @(negedge clk);
    #1;
    chk("post_rst_we", 32'(we), 32'h1);
    chk("post_rst_din", 32'(din), 32'hA0);
    chk("post_rst_grant2", 32'(grant), 32'h2);
    valid = '0;

    // Single requester, single-beat bursts: one write every cycle.
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      valid1 = 1'b1; data1 = 8'h70 + 8'(k);
      #1;
      chk($sformatf("r1_%0d_ready", k), 32'(ready1), 32'h1);
      chk($sformatf("r1_%0d_grant", k), 32'(grant1), 32'h1);
      if (k > 0) begin
        chk($sformatf("r1_%0d_we", k), 32'(we1), 32'h1);
        chk($sformatf("r1_%0d_din", k), 32'(din1), 32'(8'h70 + 8'(k - 1)));
      end
    end
    @(negedge clk);
    valid1 = 1'b0;
    #1;
    chk("r1_end_we", 32'(we1), 32'h1);
    chk("r1_end_din", 32'(din1), 32'h75);
    chk("r1_end_grant", 32'(grant1), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nfail);
    $finish;
  end

endmodule
